id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

ID/EX pipeline register of the pipelined RISC-V core. It captures the decode-stage control bundle from the controller, together with register operands, immediate, PC and register indices, and presents them to the execute stage one cycle later. It also owns load-use hazard detection: on a load-use hazard it inserts a bubble into EX and requests a decode/fetch stall. A saturating bubble counter is provided for performance monitoring.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ResultSrcD  in  2  result mux select; 2'b01 = load
- MemWriteD, ALUSrcD, RegWriteD, JalrD, JumpD, BranchD  in  1 each  decode control bits
- ALUControlD  in  4  ALU operation
- funct3D  in  3  branch/memory subtype
- RD1D, RD2D, PCD, PCPlus4D, ImmExtD  in  32 each  decode datapath values
- Rs1D, Rs2D, RdD  in  5 each  register indices
- ValidD  in  1  decode slot holds a real instruction
- StallE  in  1  hold EX register (downstream back-pressure)
- FlushE  in  1  replace EX contents with a bubble (taken branch/jump)
- BubbleCntClr  in  1  synchronous clear of the bubble counter
- ResultSrcE … BranchE, ALUControlE, funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE  out  same widths as D  registered EX copies
- lwStall  out  1  load-use hazard; upstream must stall F and D
- BubbleCnt  out  16  saturating count of inserted bubbles

## Operation
- Hazard (combinational): lwStall = ValidE & RegWriteE & (ResultSrcE==2'b01) & (RdE!=0) & ValidD & ((RdE==Rs1D)|(RdE==Rs2D)).
- Internal bubble: bubble = FlushE | (lwStall & ~StallE). lwStall never bubbles a held load.
- Per-edge update priority: reset > bubble > StallE > load.
  - bubble: all control outputs 0 (ResultSrcE=00, ALUControlE=0000, every 1-bit control 0), ValidE=0, all datapath and index outputs 0.
  - StallE (no bubble): every E output holds.
  - load: every E output takes its D counterpart.
- FlushE with StallE: flush wins and EX is bubbled.
- Counter: BubbleCnt increments by 1 on every edge where bubble=1 and saturates at 16'hFFFF.
  - BubbleCntClr forces 0 and beats a same-cycle increment.
  - Counter is independent of StallE.
- Reset mid-operation: all outputs clear immediately, regardless of clk.

## Timing
- Reset values: all E outputs 0, ValidE 0, BubbleCnt 0. lwStall therefore reads 0 during reset.
- Latency: D inputs appear on E outputs 1 cycle after the capturing edge.
- lwStall depends only on current E state and D inputs, with no registered delay. It is asserted in the same cycle the dependent instruction sits in D.
- Load-use sequence: cycle n has the load in E and the consumer in D, so lwStall=1. At edge n+1 a bubble enters E and upstream holds D, so the consumer is still in D. lwStall is now 0 because E is a bubble. At edge n+2 the consumer enters E, giving exactly one bubble.
- No combinational path from D datapath inputs to E outputs.

## Test plan
- Reset: drive every D input to all-ones and pulse reset low mid-cycle -> all E outputs 0 and BubbleCnt 0 asynchronously. After release, one edge -> E outputs mirror D.
- Load-use: load in E with RdE=5 and ResultSrcE=01, consumer in D with Rs2D=5 -> lwStall=1. Next edge gives ValidE=0, RegWriteE=0, RdE=0, BubbleCnt=1. With RdE=0 instead -> lwStall=0 and no bubble.
- Stall hold: StallE=1 for 3 cycles while D inputs change -> E outputs constant. Load-use conditions present during the stall -> lwStall=1 but the load stays in E and BubbleCnt does not change.
- Flush vs stall: FlushE=1 and StallE=1 together -> EX bubbled and BubbleCnt +1. FlushE=1 alone with BranchD=1 -> BranchE=0 and ALUControlE=0000.
- Counter: preload by 65535 bubbles then one more bubble -> stays 16'hFFFF. Assert BubbleCntClr in the same cycle as a bubble -> 0.
- Pass-through: random valid D bundles with no hazard, stall or flush -> every E output equals its D value from the previous cycle, checked bit-for-bit over 1000 cycles.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection
// and a saturating bubble counter for performance monitoring.
module id_ex_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ResultSrcD,
    input  logic        MemWriteD,
    input  logic        ALUSrcD,
    input  logic        RegWriteD,
    input  logic        JalrD,
    input  logic        JumpD,
    input  logic        BranchD,
    input  logic [3:0]  ALUControlD,
    input  logic [2:0]  funct3D,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic [31:0] ImmExtD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        ValidD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic        BubbleCntClr,
    output logic [1:0]  ResultSrcE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        RegWriteE,
    output logic        JalrE,
    output logic        JumpE,
    output logic        BranchE,
    output logic [3:0]  ALUControlE,
    output logic [2:0]  funct3E,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [31:0] ImmExtE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        ValidE,
    output logic        lwStall,
    output logic [15:0] BubbleCnt
);

    localparam int W = 191;

    logic [W-1:0] r_e;
    logic [W-1:0] w_d;
    logic [15:0]  r_cnt;
    logic         w_lw;
    logic         w_bubble;

    assign w_d = {ResultSrcD, MemWriteD, ALUSrcD, RegWriteD,
                  JalrD, JumpD, BranchD, ALUControlD, funct3D,
                  RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
                  Rs1D, Rs2D, RdD, ValidD};

    assign {ResultSrcE, MemWriteE, ALUSrcE, RegWriteE,
            JalrE, JumpE, BranchE, ALUControlE, funct3E,
            RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
            Rs1E, Rs2E, RdE, ValidE} = r_e;

    assign w_lw = ValidE & RegWriteE & (ResultSrcE == 2'b01)
                & (RdE != 5'd0) & ValidD
                & ((RdE == Rs1D) | (RdE == Rs2D));

    // A held load must stay in EX, so stall suppresses the hazard bubble
    assign w_bubble = FlushE | (w_lw & ~StallE);

    assign lwStall   = w_lw;
    assign BubbleCnt = r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e <= '0;
        end else if (w_bubble) begin
            r_e <= '0;
        end else if (!StallE) begin
            r_e <= w_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (BubbleCntClr) begin
            r_cnt <= '0;
        end else if (w_bubble && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: directed hazard, stall,
// flush, counter and reset cases plus random pass-through.
module tb_id_ex_pipe;

    typedef struct packed {
        logic [1:0]  ResultSrc;
        logic        MemWrite;
        logic        ALUSrc;
        logic        RegWrite;
        logic        Jalr;
        logic        Jump;
        logic        Branch;
        logic [3:0]  ALUControl;
        logic [2:0]  funct3;
        logic [31:0] RD1;
        logic [31:0] RD2;
        logic [31:0] PC;
        logic [31:0] PCPlus4;
        logic [31:0] Imm;
        logic [4:0]  Rs1;
        logic [4:0]  Rs2;
        logic [4:0]  Rd;
        logic        Valid;
    } bun_t;

    typedef struct packed {
        bun_t        e;
        logic [15:0] cnt;
        logic        lw;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic StallE = 1'b0;
    logic FlushE = 1'b0;
    logic BubbleCntClr = 1'b0;
    bun_t dv = '1;
    bun_t ev;

    logic [1:0]  ResultSrcE;
    logic        MemWriteE, ALUSrcE, RegWriteE;
    logic        JalrE, JumpE, BranchE;
    logic [3:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        ValidE, lwStall;
    logic [15:0] BubbleCnt;

    int total = 0;
    int bad = 0;

    ent_t  sb[$];
    string nmq[$];

    bun_t        exp_e = '0;
    logic [15:0] exp_cnt = '0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .reset(reset),
        .ResultSrcD(dv.ResultSrc), .MemWriteD(dv.MemWrite),
        .ALUSrcD(dv.ALUSrc), .RegWriteD(dv.RegWrite),
        .JalrD(dv.Jalr), .JumpD(dv.Jump), .BranchD(dv.Branch),
        .ALUControlD(dv.ALUControl), .funct3D(dv.funct3),
        .RD1D(dv.RD1), .RD2D(dv.RD2), .PCD(dv.PC),
        .PCPlus4D(dv.PCPlus4), .ImmExtD(dv.Imm),
        .Rs1D(dv.Rs1), .Rs2D(dv.Rs2), .RdD(dv.Rd),
        .ValidD(dv.Valid), .StallE(StallE), .FlushE(FlushE),
        .BubbleCntClr(BubbleCntClr),
        .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
        .ALUSrcE(ALUSrcE), .RegWriteE(RegWriteE),
        .JalrE(JalrE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUControlE(ALUControlE), .funct3E(funct3E),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ValidE(ValidE), .lwStall(lwStall), .BubbleCnt(BubbleCnt)
    );

    assign ev = {ResultSrcE, MemWriteE, ALUSrcE, RegWriteE,
                 JalrE, JumpE, BranchE, ALUControlE, funct3E,
                 RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
                 Rs1E, Rs2E, RdE, ValidE};

    // Monitor: outputs are stable at the falling edge
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            ent_t  en;
            string nm;
            en = sb.pop_front();
            nm = nmq.pop_front();
            total++;
            if (ev !== en.e) begin
                bad++;
                $display("FAIL %s ebundle got=%h want=%h", nm, ev, en.e);
            end
            total++;
            if (BubbleCnt !== en.cnt) begin
                bad++;
                $display("FAIL %s BubbleCnt got=%h want=%h",
                         nm, BubbleCnt, en.cnt);
            end
            total++;
            if (lwStall !== en.lw) begin
                bad++;
                $display("FAIL %s lwStall got=%b want=%b",
                         nm, lwStall, en.lw);
            end
        end
    end

    function automatic bun_t ins(input logic [1:0] rs,
                                 input logic rw,
                                 input logic [4:0] rd, r1, r2,
                                 input logic [31:0] s);
        bun_t b;
        b.ResultSrc  = rs;
        b.MemWrite   = s[7];
        b.ALUSrc     = s[8];
        b.RegWrite   = rw;
        b.Jalr       = 1'b0;
        b.Jump       = 1'b0;
        b.Branch     = s[9];
        b.ALUControl = s[3:0];
        b.funct3     = s[6:4];
        b.RD1        = s;
        b.RD2        = ~s;
        b.PC         = s << 2;
        b.PCPlus4    = (s << 2) + 32'd4;
        b.Imm        = s ^ 32'h5a5a_5a5a;
        b.Rs1        = r1;
        b.Rs2        = r2;
        b.Rd         = rd;
        b.Valid      = 1'b1;
        return b;
    endfunction

    function automatic void push(input string nm, input logic lw);
        ent_t en;
        en.e   = exp_e;
        en.cnt = exp_cnt;
        en.lw  = lw;
        sb.push_back(en);
        nmq.push_back(nm);
    endfunction

    // Caller sits just after a rising edge; lw is the hand value
    task automatic cyc(input bun_t d, input logic st, fl, clr,
                       input logic lw, input string nm);
        logic bub;
        dv = d;
        StallE = st;
        FlushE = fl;
        BubbleCntClr = clr;
        push(nm, lw);
        bub = fl | (lw & ~st);
        if (bub) begin
            exp_e = '0;
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end else if (!st) begin
            exp_e = d;
        end
        if (clr) exp_cnt = '0;
        @(posedge clk);
        #1;
    endtask

    bun_t L, C, N, L0, C0, C1, C2, C3, B, R;

    initial begin
        L  = ins(2'b01, 1'b1, 5'd5, 5'd1, 5'd2, 32'd100);
        C  = ins(2'b00, 1'b1, 5'd9, 5'd7, 5'd5, 32'd200);
        N  = ins(2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 32'd300);
        L0 = ins(2'b01, 1'b1, 5'd0, 5'd1, 5'd2, 32'd400);
        C0 = ins(2'b00, 1'b1, 5'd3, 5'd0, 5'd0, 32'd500);
        C1 = ins(2'b00, 1'b1, 5'd9, 5'd5, 5'd3, 32'd600);
        C2 = ins(2'b00, 1'b1, 5'd9, 5'd5, 5'd4, 32'd700);
        C3 = ins(2'b00, 1'b0, 5'd9, 5'd8, 5'd5, 32'd800);
        B  = ins(2'b00, 1'b1, 5'd4, 5'd1, 5'd1, 32'd900);
        B.Branch = 1'b1;

        dv = '1;
        @(posedge clk);
        #1;
        push("rst_hold", 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp_e = dv;
        @(posedge clk);
        #1;

        cyc('1, 1'b0, 1'b0, 1'b0, 1'b0, "mirror_ones");
        reset = 1'b0;
        #1;
        exp_e = '0;
        push("rst_async", 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        exp_e = dv;
        @(posedge clk);
        #1;
        cyc(L, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

        cyc(C, 1'b0, 1'b0, 1'b0, 1'b1, "lu_det");
        cyc(C, 1'b0, 1'b0, 1'b0, 1'b0, "lu_bubble");
        cyc(L0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_cons");
        cyc(C0, 1'b0, 1'b0, 1'b0, 1'b0, "rd0_load");
        cyc(N, 1'b0, 1'b0, 1'b0, 1'b0, "rd0_nohaz");
        cyc(L, 1'b0, 1'b0, 1'b0, 1'b0, "rd0_pass");

        cyc(C1, 1'b1, 1'b0, 1'b0, 1'b1, "stall1");
        cyc(C2, 1'b1, 1'b0, 1'b0, 1'b1, "stall2");
        cyc(C3, 1'b1, 1'b0, 1'b0, 1'b1, "stall3");
        cyc(C3, 1'b0, 1'b0, 1'b0, 1'b1, "stall_rel");
        cyc(B, 1'b1, 1'b1, 1'b0, 1'b0, "st_bubble");
        cyc(B, 1'b0, 1'b1, 1'b0, 1'b0, "flush_stall");
        cyc(N, 1'b0, 1'b0, 1'b0, 1'b0, "flush_br");
        cyc(N, 1'b0, 1'b0, 1'b1, 1'b0, "cnt_clr");

        for (int i = 0; i < 65535; i++)
            cyc(N, 1'b0, 1'b1, 1'b0, 1'b0, "sat_fill");
        cyc(N, 1'b0, 1'b1, 1'b0, 1'b0, "sat_top");
        cyc(N, 1'b0, 1'b1, 1'b1, 1'b0, "sat_hold");
        cyc(N, 1'b0, 1'b0, 1'b0, 1'b0, "clr_beats_inc");

        for (int i = 0; i < 1000; i++) begin
            int unsigned k;
            R = {$urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom};
            k = $urandom_range(0, 2);
            R.ResultSrc = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : 2'b11;
            cyc(R, 1'b0, 1'b0, 1'b0, 1'b0, "pass");
        end
        cyc(N, 1'b0, 1'b0, 1'b0, 1'b0, "pass_last");

        begin
            int w;
            w = 0;
            while (sb.size() != 0 && w < 10) begin
                @(posedge clk);
                w++;
            end
            if (sb.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain left=%0d want=0", sb.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
